// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared defaults, FSM encoding and counter width for wb_regfile
package wb_regfile_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int NREG_LOG2_DEF = 3;
  localparam int CNT_W         = 16;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/regfile_core.sv
// rtl/regfile_core.sv - register storage: one write port, two combinational read ports
// Ports:
//   clk, resetn          clock, synchronous active-low clear of every register
//   we, waddr, wdata     write port, applied at the rising edge
//   raddr1/2, rdata1/2   combinational read ports
module regfile_core
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NREG_LOG2 = NREG_LOG2_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 we,
  input  logic [NREG_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [NREG_LOG2-1:0] raddr1,
  input  logic [NREG_LOG2-1:0] raddr2,
  output logic [DATA_W-1:0]    rdata1,
  output logic [DATA_W-1:0]    rdata2
);

  localparam int NREG = 1 << NREG_LOG2;

  logic [NREG-1:0][DATA_W-1:0] mem_q;
  logic [NREG-1:0][DATA_W-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback register file with RUN/HALT error FSM and commit counter
// Optional feature: define WB_REGFILE_BYPASS_EN to forward the committing value to
// a read port addressing the register being written in the same cycle.
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   memDataIn, aluResIn, MemToRegIn   writeback data sources and selector
//   writeRegIn, RegWriteIn,
//   writeRegValidIn, errIn            destination, write controls, pipeline error
//   read1RegSel/read2RegSel           read indices -> read1Data/read2Data
//   wbData                            selected writeback value (combinational)
//   commitCount, halted, errOut       committed-write count, HALT state, sticky error
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NREG_LOG2 = NREG_LOG2_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    memDataIn,
  input  logic [DATA_W-1:0]    aluResIn,
  input  logic [NREG_LOG2-1:0] writeRegIn,
  input  logic                 MemToRegIn,
  input  logic                 RegWriteIn,
  input  logic                 writeRegValidIn,
  input  logic                 errIn,
  input  logic [NREG_LOG2-1:0] read1RegSel,
  input  logic [NREG_LOG2-1:0] read2RegSel,
  output logic [DATA_W-1:0]    read1Data,
  output logic [DATA_W-1:0]    read2Data,
  output logic [DATA_W-1:0]    wbData,
  output logic [CNT_W-1:0]     commitCount,
  output logic                 halted,
  output logic                 errOut
);

  wb_state_e          state_q, state_d;
  logic               err_q, err_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               commit;
  logic [DATA_W-1:0]  core_rd1, core_rd2;

  assign wbData = MemToRegIn ? memDataIn : aluResIn;

  // The instruction carrying the error never commits.
  assign commit = RegWriteIn & writeRegValidIn & (state_q == ST_RUN) & ~errIn;

  regfile_core #(
    .DATA_W   (DATA_W),
    .NREG_LOG2(NREG_LOG2)
  ) u_core (
    .clk   (clk),
    .resetn(rst),
    .we    (commit),
    .waddr (writeRegIn),
    .wdata (wbData),
    .raddr1(read1RegSel),
    .raddr2(read2RegSel),
    .rdata1(core_rd1),
    .rdata2(core_rd2)
  );

`ifdef WB_REGFILE_BYPASS_EN
  assign read1Data = (commit && (read1RegSel == writeRegIn)) ? wbData : core_rd1;
  assign read2Data = (commit && (read2RegSel == writeRegIn)) ? wbData : core_rd2;
`else
  assign read1Data = core_rd1;
  assign read2Data = core_rd2;
`endif

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (commit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // HALT is absorbing; only reset leaves it.
    if ((state_q == ST_RUN) && errIn) begin
      state_d  = ST_HALT;
      err_d    = 1'b1;
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign halted      = halted_q;
  assign errOut      = err_q;
  assign commitCount = cnt_q;

endmodule
